// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared widths for the square-root datapath and its result FIFO.
package sqrt_pkg;
  localparam int SQRT_ROOT_W     = 8;
  localparam int SQRT_FIFO_DEPTH = 4;
  localparam int SQRT_PTR_W      = $clog2(SQRT_FIFO_DEPTH);
  localparam int SQRT_CNT_W      = SQRT_PTR_W + 1;
endpackage

// File: rtl/sqrt_result_fifo_if.sv
// sqrt_result_fifo_if: valid/ready result stream from the FIFO head to its consumer.
interface sqrt_result_fifo_if
  import sqrt_pkg::*;
#(
  parameter int DATA_WIDTH = SQRT_ROOT_W
);
  logic                  res_valid_o;
  logic                  res_ready_i;
  logic [DATA_WIDTH-1:0] res_data_o;
  modport master (output res_valid_o, res_data_o, input res_ready_i);
  modport slave  (input res_valid_o, res_data_o, output res_ready_i);
endinterface

// File: rtl/sqrt_result_fifo_rise_detect.sv
// rise_detect: one-cycle pulse on a 0->1 transition of d; RST_VAL=1 suppresses a pulse for d held high through reset.
module rise_detect #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic q;
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= RST_VAL;
    else     q <= d;
  assign rise = d & ~q;
endmodule

// File: rtl/sqrt_result_fifo.sv
// sqrt_result_fifo: show-ahead FIFO capturing the datapath root on each rising edge of ready_i.
module sqrt_result_fifo
  import sqrt_pkg::*;
#(
  parameter int DATA_WIDTH = SQRT_ROOT_W,
  parameter int DEPTH      = SQRT_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ready_i,
  input  logic [DATA_WIDTH-1:0]    root_i,
  sqrt_result_fifo_if.master       res,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     overflow_o,
  input  logic                     clr_ovf_i
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  capture, pop, wr, ovf_set;
  rise_detect #(.RST_VAL(1'b1)) u_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (ready_i),
    .rise (capture)
  );
  assign full_o          = count == CW'(DEPTH);
  assign empty_o         = count == '0;
  assign count_o         = count;
  assign res.res_valid_o = ~empty_o;
  assign res.res_data_o  = mem[rd_ptr];
  assign pop             = res.res_valid_o & res.res_ready_i;
  // When full, a simultaneous pop frees the head slot, which is also the tail slot.
  assign wr              = capture & (~full_o | pop);
  assign ovf_set         = capture & full_o & ~pop;
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= root_i;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
    end else begin
      wr_ptr     <= wr ? wr_ptr + PW'(1) : wr_ptr;
      rd_ptr     <= pop ? rd_ptr + PW'(1) : rd_ptr;
      count      <= count + CW'(wr) - CW'(pop);
      overflow_o <= ovf_set ? 1'b1 : clr_ovf_i ? 1'b0 : overflow_o;
    end
endmodule
